// File: rtl/logistic_map_seq.sv
// Logistic-map iteration sequencer: drives an external multiplier twice per step (x*(1-x), then r*t).
// Optional multiplier watchdog enabled by defining LOGMAP_TIMEOUT_EN.
module logistic_map_seq #(
    parameter int W           = 18,
    parameter int FRAC_X      = 17,
    parameter int FRAC_R      = 15,
    parameter int MUL_TIMEOUT = 63
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic           start,
    input  logic [W-1:0]   seed,
    input  logic [W-1:0]   r_coef,
    input  logic [15:0]    iter_count,
    output logic           busy,
    output logic           x_valid,
    output logic [W-1:0]   x_out,
    output logic           done,
    output logic           err,
    output logic           mul_start,
    output logic [W-1:0]   mul_a,
    output logic [W-1:0]   mul_b,
    input  logic [2*W-1:0] mul_result,
    input  logic           mul_done
);

    localparam int SW                  = 2*W - FRAC_R;
    localparam logic [W-1:0]   ONE     = W'(1) << FRAC_X;
    localparam logic [2*W-1:0] T_LIMIT = (2*W)'(ONE) << FRAC_X;
    localparam logic [SW-1:0]  X_LIMIT = SW'(ONE);
    localparam logic [5:0]     TMO_LAST = 6'(MUL_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, LOAD1, MUL1, LOAD2, MUL2, EMIT, FINISH} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  x_q, r_q, t_q;
    logic [15:0]   rem_q;
    logic          in_mul, tmo_hit;
    logic [W-1:0]  seed_sat, t_calc, xn_calc;
    logic [SW-1:0] shr;

    assign in_mul    = (state_q == MUL1) || (state_q == MUL2);
    assign mul_start = in_mul;
    assign seed_sat  = (seed > ONE) ? ONE : seed;

    // Operands are valid through LOADx (latched by the multiplier) and held through MULx.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state_q)
            LOAD1, MUL1: begin mul_a = x_q; mul_b = ONE - x_q; end
            LOAD2, MUL2: begin mul_a = r_q; mul_b = t_q;       end
            default: ;
        endcase
    end

    assign t_calc  = (mul_result >= T_LIMIT) ? ONE : mul_result[FRAC_X+W-1:FRAC_X];
    assign shr     = mul_result[2*W-1:FRAC_R];
    assign xn_calc = (shr > X_LIMIT) ? ONE : shr[W-1:0];

`ifdef LOGMAP_TIMEOUT_EN
    logic [5:0] tmo_cnt;

    always_ff @(posedge CLK) begin
        if (!RST_N || !in_mul || mul_done) tmo_cnt <= '0;
        else                               tmo_cnt <= tmo_cnt + 6'd1;
    end

    assign tmo_hit = in_mul && !mul_done && (tmo_cnt == TMO_LAST);
`else
    logic unused_tmo;
    assign unused_tmo = ^TMO_LAST;
    assign tmo_hit    = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (!RST_N) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (iter_count == 16'd0) ? FINISH : LOAD1;
            LOAD1:   state_d = MUL1;
            MUL1:    if (mul_done) state_d = LOAD2; else if (tmo_hit) state_d = FINISH;
            LOAD2:   state_d = MUL2;
            MUL2:    if (mul_done) state_d = EMIT;  else if (tmo_hit) state_d = FINISH;
            EMIT:    state_d = (rem_q == 16'd1) ? FINISH : LOAD1;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            busy    <= 1'b0;
            x_valid <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            x_out   <= '0;
            x_q     <= '0;
            r_q     <= '0;
            t_q     <= '0;
            rem_q   <= '0;
        end else begin
            x_valid <= 1'b0;
            done    <= 1'b0;
            err     <= tmo_hit;
            case (state_q)
                IDLE: if (start) begin
                    x_q   <= seed_sat;
                    r_q   <= r_coef;
                    rem_q <= iter_count;
                    busy  <= 1'b1;
                end
                MUL1: if (mul_done) t_q <= t_calc;
                // x_q is not an operand again until the next LOAD1, so it can take xn early.
                MUL2: if (mul_done) x_q <= xn_calc;
                EMIT: begin
                    x_out   <= x_q;
                    x_valid <= 1'b1;
                    rem_q   <= rem_q - 16'd1;
                end
                FINISH: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
